// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a per-bit oversampling counter,
// a one-byte output buffer and sticky framing/overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstd,
    input  logic       rxd,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t state, state_n;
    logic s1, rxs;
    logic [CW-1:0] clk_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic accept, accept_n, clr_cnt, sample, to_data, ferr_set, counting;

    assign busy = (state != IDLE);
    assign counting = (state == START) || (state == DATA) || (state == STOP);

    always_comb begin
        state_n  = state;
        clr_cnt  = 1'b0;
        sample   = 1'b0;
        to_data  = 1'b0;
        accept_n = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt = !rxs;
                state_n = rxs ? IDLE : START;
            end
            START: if (clk_cnt == HALF) begin
                clr_cnt = 1'b1;
                to_data = !rxs;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (clk_cnt == FULL) begin
                clr_cnt = 1'b1;
                sample  = 1'b1;
                state_n = (bit_cnt == 3'd7) ? STOP : DATA;
            end
            STOP: if (clk_cnt == FULL) begin
                clr_cnt  = 1'b1;
                accept_n = rxs;
                ferr_set = !rxs;
                state_n  = rxs ? IDLE : WAIT_HI;
            end
            WAIT_HI: state_n = rxs ? IDLE : WAIT_HI;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            s1        <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            accept    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s1      <= rxd;
            rxs     <= s1;
            state   <= state_n;
            clk_cnt <= clr_cnt ? '0 : (counting ? clk_cnt + 1'b1 : clk_cnt);
            bit_cnt <= to_data ? 3'd0 : (sample ? bit_cnt + 3'd1 : bit_cnt);
            if (sample)
                shift[bit_cnt] <= rxs;
            accept <= accept_n;
            // A read in the load cycle frees the buffer, so the new byte wins
            if (accept && (!rx_valid || rx_rd))
                rx_data <= shift;
            rx_valid  <= accept ? 1'b1 : (rx_rd ? 1'b0 : rx_valid);
            overrun   <= (accept && rx_valid && !rx_rd) || (overrun && !rx_rd);
            frame_err <= ferr_set || (frame_err && !rx_rd);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expectations.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rstd = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err, busy;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rstd(rstd), .rxd(rxd), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
        .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b);
        drive_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_line(b[i], CPB);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b);
        drive_line(1'b1, CPB);
    endtask

    task automatic read_pulse();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 400 && !rx_valid; i++) @(negedge clk);
        check(tag, 32'(rx_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstd = 1'b1;
        drive_line(1'b1, 5);

        // basic byte with latency window
        lat = 0;
        fork
            send(8'h55);
            while (!rx_valid && lat < 200) begin
                @(negedge clk);
                lat++;
            end
        join
        check("basic_lat", 32'(lat >= 150 && lat <= 160), 32'd1);
        check("basic_data", 32'(rx_data), 32'h55);
        check("basic_ferr", 32'(frame_err), 32'd0);
        check("basic_ovr", 32'(overrun), 32'd0);
        read_pulse();
        check("basic_rd", 32'(rx_valid), 32'd0);

        // back-to-back frames
        fork
            begin
                send(8'hA3);
                send(8'h0F);
            end
            begin
                wait_valid("b2b_v1");
                check("b2b_d1", 32'(rx_data), 32'hA3);
                check("b2b_gap", 32'(busy), 32'd0);
                read_pulse();
                wait_valid("b2b_v2");
                check("b2b_d2", 32'(rx_data), 32'h0F);
                read_pulse();
            end
        join
        check("b2b_ferr", 32'(frame_err), 32'd0);
        check("b2b_ovr", 32'(overrun), 32'd0);
        drive_line(1'b1, 5);

        // glitch on the line
        drive_line(1'b0, 3);
        drive_line(1'b1, 20);
        check("gl_busy", 32'(busy), 32'd0);
        check("gl_valid", 32'(rx_valid), 32'd0);
        check("gl_ferr", 32'(frame_err), 32'd0);
        send(8'h81);
        check("gl_v", 32'(rx_valid), 32'd1);
        check("gl_data", 32'(rx_data), 32'h81);
        read_pulse();

        // framing error: stop bit low for two bit times
        send_bits(8'h3C);
        drive_line(1'b0, 2 * CPB);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_valid", 32'(rx_valid), 32'd0);
        check("fe_waithi", 32'(busy), 32'd1);
        drive_line(1'b1, 5);
        check("fe_idle", 32'(busy), 32'd0);
        read_pulse();
        check("fe_clr", 32'(frame_err), 32'd0);

        // overrun
        send(8'h11);
        drive_line(1'b1, 4);
        send(8'h22);
        drive_line(1'b1, 4);
        check("ov_flag", 32'(overrun), 32'd1);
        check("ov_data", 32'(rx_data), 32'h11);
        check("ov_valid", 32'(rx_valid), 32'd1);
        read_pulse();
        check("ov_clr", 32'(overrun), 32'd0);
        check("ov_rd", 32'(rx_valid), 32'd0);

        // read strobe in the exact load cycle
        send(8'h11);
        drive_line(1'b1, 4);
        fork
            send(8'h22);
            begin
                repeat (155) @(negedge clk);
                rx_rd = 1'b1;
                @(negedge clk);
                rx_rd = 1'b0;
            end
        join
        check("sim_data", 32'(rx_data), 32'h22);
        check("sim_valid", 32'(rx_valid), 32'd1);
        check("sim_ovr", 32'(overrun), 32'd0);
        drive_line(1'b1, 4);

        // reset during bit 4 of 0xF0
        fork
            send(8'hF0);
            begin
                repeat (88) @(negedge clk);
                rstd = 1'b0;
                repeat (2) @(negedge clk);
                check("mr_valid", 32'(rx_valid), 32'd0);
                check("mr_data", 32'(rx_data), 32'h0);
                check("mr_busy", 32'(busy), 32'd0);
                check("mr_ovr", 32'(overrun), 32'd0);
                rstd = 1'b1;
            end
        join
        drive_line(1'b1, 20);
        check("mr_novalid", 32'(rx_valid), 32'd0);
        check("mr_noferr", 32'(frame_err), 32'd0);
        send(8'hF0);
        check("mr_v", 32'(rx_valid), 32'd1);
        check("mr_again", 32'(rx_data), 32'hF0);
        check("mr_ferr", 32'(frame_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
